prio_encoder_scan: RTL and testbench

Parametrised, registered successor to the lab's 8-to-3 priority encoder with 7-segment output. It takes WIDTH raw switch/request lines and runs them through a synchroniser and a debounce filter. It then priority-encodes the result, either MSB-first or LSB-first, with a freeze option. The index is driven in hex onto a time-multiplexed NDIG-digit 7-segment display. It sits between board switches and the seven-segment bank in the njudlcolab examples.

---
 rtl/prio_encoder_scan_if.sv | 27 ++
 rtl/prio_encoder_scan.sv | 155 +++++++++++++++
 tb/tb_prio_encoder_scan.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/prio_encoder_scan_if.sv
// Request and display bundle for prio_encoder_scan.
// The master side drives the request lines; the slave side (the encoder) returns index and display.
interface prio_encoder_scan_if #(
    parameter int WIDTH = 16,
    parameter int NDIG  = 2
);
    localparam int IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] sw;
    logic             lsb_first;
    logic             freeze;
    logic             valid;
    logic [IDX_W-1:0] idx;
    logic             changed;
    logic [7:0]       seg;
    logic [NDIG-1:0]  an;

    modport master (
        output sw, lsb_first, freeze,
        input  valid, idx, changed, seg, an
    );

    modport slave (
        input  sw, lsb_first, freeze,
        output valid, idx, changed, seg, an
    );
endinterface

// File: rtl/prio_encoder_scan.sv
// Synchronised, debounced priority encoder driving a multiplexed hex 7-segment display.
// Inputs are level requests; there is no handshake, and every output is registered.
module prio_encoder_scan #(
    parameter int WIDTH      = 16,
    parameter int DEB_CYCLES = 4,
    parameter int NDIG       = 2,
    parameter int SCAN_DIV   = 1024
) (
    input  logic clk,
    input  logic rst_n,
    prio_encoder_scan_if.slave bus
);
    localparam int IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int SC_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DIG_W = (NDIG > 1) ? $clog2(NDIG) : 1;

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
    localparam logic [SC_W-1:0]  SCAN_LAST = SC_W'(SCAN_DIV - 1);
    localparam logic [DIG_W-1:0] DIG_LAST  = DIG_W'(NDIG - 1);

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;
    logic [WIDTH-1:0] r_cand;
    logic [WIDTH-1:0] r_stable;
    logic [CNT_W-1:0] r_cnt;

    logic             r_valid;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W:0]   r_last;
    logic             r_changed;

    logic [SC_W-1:0]  r_scan;
    logic [DIG_W-1:0] r_dig;
    logic [7:0]       r_seg;
    logic [NDIG-1:0]  r_an;

    logic             w_enc_valid;
    logic [IDX_W-1:0] w_enc_idx;
    logic [4*NDIG-1:0] w_idx_pad;
    logic [3:0]       w_nib;
    logic [7:0]       w_seg_next;
    logic [NDIG-1:0]  w_an_next;

    // Active-low glyphs, bit order a,b,c,d,e,f,g,dp; dp is left dark here.
    function automatic logic [7:0] hex_glyph(input logic [3:0] n);
        case (n)
            4'h0: hex_glyph = 8'h03;
            4'h1: hex_glyph = 8'h9F;
            4'h2: hex_glyph = 8'h25;
            4'h3: hex_glyph = 8'h0D;
            4'h4: hex_glyph = 8'h99;
            4'h5: hex_glyph = 8'h49;
            4'h6: hex_glyph = 8'h41;
            4'h7: hex_glyph = 8'h1F;
            4'h8: hex_glyph = 8'h01;
            4'h9: hex_glyph = 8'h09;
            4'hA: hex_glyph = 8'h11;
            4'hB: hex_glyph = 8'hC1;
            4'hC: hex_glyph = 8'h63;
            4'hD: hex_glyph = 8'h85;
            4'hE: hex_glyph = 8'h61;
            default: hex_glyph = 8'h71;
        endcase
    endfunction

    // Any mismatch between s2 and the candidate restarts the stability count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1     <= '0;
            r_s2     <= '0;
            r_cand   <= '0;
            r_stable <= '0;
            r_cnt    <= '0;
        end else begin
            r_s1 <= bus.sw;
            r_s2 <= r_s1;
            if (r_s2 != r_cand) begin
                r_cand <= r_s2;
                r_cnt  <= '0;
            end else if (r_cnt == DEB_LAST) begin
                r_stable <= r_cand;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Later loop iterations override earlier ones, so iteration order picks the winner.
    always_comb begin
        w_enc_idx   = '0;
        w_enc_valid = |r_stable;
        if (bus.lsb_first) begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (r_stable[i]) w_enc_idx = IDX_W'(i);
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (r_stable[i]) w_enc_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid   <= 1'b0;
            r_idx     <= '0;
            r_last    <= '0;
            r_changed <= 1'b0;
        end else begin
            if (!bus.freeze) begin
                r_valid <= w_enc_valid;
                r_idx   <= w_enc_idx;
            end
            r_last    <= {r_valid, r_idx};
            r_changed <= ({r_valid, r_idx} != r_last);
        end
    end

    assign w_idx_pad = (4*NDIG)'(r_idx);
    assign w_nib     = w_idx_pad[{r_dig, 2'b00} +: 4];
    assign w_an_next = ~(NDIG'(1) << r_dig);

    always_comb begin
        w_seg_next = 8'hFD;
        if (r_valid) begin
            w_seg_next = hex_glyph(w_nib);
            if (r_dig == '0) w_seg_next[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan <= '0;
            r_dig  <= '0;
            r_seg  <= 8'hFF;
            r_an   <= '1;
        end else begin
            if (r_scan == SCAN_LAST) begin
                r_scan <= '0;
                r_dig  <= (r_dig == DIG_LAST) ? '0 : r_dig + 1'b1;
            end else begin
                r_scan <= r_scan + 1'b1;
            end
            r_seg <= w_seg_next;
            r_an  <= w_an_next;
        end
    end

    assign bus.valid   = r_valid;
    assign bus.idx     = r_idx;
    assign bus.changed = r_changed;
    assign bus.seg     = r_seg;
    assign bus.an      = r_an;
endmodule

// File: tb/tb_prio_encoder_scan.sv
// Directed bench for prio_encoder_scan with WIDTH=16, DEB_CYCLES=4, NDIG=2, SCAN_DIV=4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_prio_encoder_scan;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    prio_encoder_scan_if #(.WIDTH(16), .NDIG(2)) bus ();

    prio_encoder_scan #(
        .WIDTH(16), .DEB_CYCLES(4), .NDIG(2), .SCAN_DIV(4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    initial begin
        logic [1:0] a0;
        logic [1:0] an_exp;
        bit         found;
        n_checks      = 0;
        n_errors      = 0;
        rst_n         = 1'b0;
        bus.sw        = '0;
        bus.lsb_first = 1'b0;
        bus.freeze    = 1'b0;
        step(3);

        // Reset state
        chk("rst_valid",   32'(bus.valid),   32'd0);
        chk("rst_idx",     32'(bus.idx),     32'd0);
        chk("rst_changed", 32'(bus.changed), 32'd0);
        chk("rst_seg",     32'(bus.seg),     32'hFF);
        chk("rst_an",      32'(bus.an),      32'h3);

        // Priority, latency and direction
        rst_n  = 1'b1;
        bus.sw = 16'h0090;
        step(7);
        chk("lat_not_yet", 32'(bus.valid), 32'd0);
        step(1);
        chk("msb_valid", 32'(bus.valid),   32'd1);
        chk("msb_idx",   32'(bus.idx),     32'd7);
        chk("msb_chg0",  32'(bus.changed), 32'd0);
        step(1);
        chk("msb_chg1",  32'(bus.changed), 32'd1);
        step(1);
        chk("msb_chg2",  32'(bus.changed), 32'd0);
        bus.lsb_first = 1'b1;
        step(1);
        chk("lsb_idx",   32'(bus.idx),     32'd4);
        step(1);
        chk("lsb_chg",   32'(bus.changed), 32'd1);
        step(1);
        chk("lsb_chg_end", 32'(bus.changed), 32'd0);
        bus.lsb_first = 1'b0;
        step(3);
        chk("back_msb", 32'(bus.idx), 32'd7);

        // Asynchronous reset pulse between edges, mid-scan
        step(1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_valid",   32'(bus.valid),   32'd0);
        chk("arst_idx",     32'(bus.idx),     32'd0);
        chk("arst_changed", 32'(bus.changed), 32'd0);
        chk("arst_seg",     32'(bus.seg),     32'hFF);
        chk("arst_an",      32'(bus.an),      32'h3);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step(1);
            chk("rel_quiet", 32'({bus.valid, bus.changed}), 32'd0);
        end
        step(1);
        chk("rel_idx", 32'({bus.valid, bus.idx}), 32'h17);

        // Debounce: short pulse rejected, long pulse accepted
        bus.sw = 16'h0000;
        step(12);
        chk("clear_valid", 32'(bus.valid), 32'd0);
        bus.sw = 16'h8000;
        step(3);
        bus.sw = 16'h0000;
        for (int i = 0; i < 12; i++) begin
            step(1);
            chk("short_pulse", 32'({bus.valid, bus.changed}), 32'd0);
        end
        bus.sw = 16'h8000;
        step(5);
        bus.sw = 16'h0000;
        step(3);
        chk("long_pulse", 32'({bus.valid, bus.idx}), 32'h1F);
        step(1);
        chk("long_chg", 32'(bus.changed), 32'd1);

        // Freeze holds idx/valid while debounce keeps running
        bus.sw = 16'h0090;
        step(12);
        chk("pre_freeze", 32'({bus.valid, bus.idx}), 32'h17);
        bus.freeze = 1'b1;
        bus.sw     = 16'h0001;
        for (int i = 0; i < 12; i++) begin
            step(1);
            chk("frozen", 32'({bus.valid, bus.idx, bus.changed}), 32'h2E);
        end
        bus.freeze = 1'b0;
        step(1);
        chk("unfreeze_idx", 32'({bus.valid, bus.idx}), 32'h10);
        step(1);
        chk("unfreeze_chg", 32'(bus.changed), 32'd1);

        // Display of 0x0B: digit0 'b' with dp, digit1 '0'
        bus.sw = 16'h0800;
        step(12);
        chk("disp_idx", 32'({bus.valid, bus.idx}), 32'h1B);
        a0    = bus.an;
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            step(1);
            if (bus.an != a0) found = 1'b1;
        end
        chk("scan_edge", 32'(found), 32'd1);
        a0 = bus.an;
        chk("an_onehot", 32'((a0 == 2'b10) || (a0 == 2'b01)), 32'd1);
        for (int k = 0; k < 8; k++) begin
            an_exp = (k < 4) ? a0 : ~a0;
            chk("scan_an", 32'(bus.an), 32'(an_exp));
            chk("scan_seg", 32'(bus.seg), (an_exp == 2'b10) ? 32'hC0 : 32'h03);
            step(1);
        end

        // No request: dashes on every digit
        bus.sw = 16'h0000;
        step(12);
        chk("none_valid", 32'(bus.valid), 32'd0);
        for (int k = 0; k < 8; k++) begin
            chk("dash_seg", 32'(bus.seg), 32'hFD);
            step(1);
        end

        // All requests set, both directions
        bus.sw = 16'hFFFF;
        step(12);
        chk("all_msb", 32'({bus.valid, bus.idx}), 32'h1F);
        bus.lsb_first = 1'b1;
        step(1);
        chk("all_lsb", 32'({bus.valid, bus.idx}), 32'h10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
